// File: rtl/display_pkg.sv
// Shared types and constants for the score display scanner.
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int VALUE_W    = 14;
   localparam logic [VALUE_W-1:0] VALUE_MAX = 14'd9999;

   typedef logic [3:0] digit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } conv_state_t;

   // Double-dabble correction: bump every nibble >= 5 by 3 before the shift.
   function automatic logic [4*NUM_DIGITS-1:0] add3_nibbles(input logic [4*NUM_DIGITS-1:0] a);
      logic [4*NUM_DIGITS-1:0] r;
      digit_t                  d;
      r = a;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = a[4*i +: 4];
         if (d >= 4'd5) r[4*i +: 4] = d + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Free-running sequential binary-to-BCD converter (shift-and-add-3).
// One conversion takes 16 cycles: IDLE capture, 14 SHIFT steps, LATCH.
module bin_to_bcd_serial
   import display_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [VALUE_W-1:0]      value,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    busy
);

   conv_state_t             state, state_next;
   logic [VALUE_W-1:0]      bin;
   logic [4*NUM_DIGITS-1:0] acc;
   logic [3:0]              cnt;
   logic [VALUE_W-1:0]      value_sat;
   logic [4*NUM_DIGITS+VALUE_W-1:0] shifted;

   // Clamp out-of-range scores so the display never shows a 5th digit.
   always_comb value_sat = (value > VALUE_MAX) ? VALUE_MAX : value;

   // One correction-and-shift step of the {accumulator, binary} register.
   always_comb shifted = {add3_nibbles(acc), bin} << 1;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state logic: conversions run back to back forever.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = SHIFT;
         SHIFT:   if (cnt == 4'd0) state_next = LATCH;
         LATCH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: busy covers the 14 SHIFT cycles plus the LATCH cycle.
   always_comb busy = (state != IDLE);

   // Datapath: capture in IDLE, iterate in SHIFT, publish in LATCH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bin    <= '0;
         acc    <= '0;
         cnt    <= '0;
         digits <= '0;
      end else begin
         case (state)
            IDLE: begin
               bin <= value_sat;
               acc <= '0;
               cnt <= 4'(VALUE_W - 1);
            end
            SHIFT: begin
               acc <= shifted[4*NUM_DIGITS+VALUE_W-1 -: 4*NUM_DIGITS];
               bin <= shifted[VALUE_W-1:0];
               cnt <= cnt - 4'd1;
            end
            LATCH: digits <= acc;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/score_display_scanner.sv
// Converts a binary score to BCD and time-multiplexes the four digits onto a
// shared bcd bus with active-low anode enables and leading-zero blanking.
module score_display_scanner
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [VALUE_W-1:0]      value,
   output logic [3:0]              bcd,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [1:0]              digit_sel,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    busy
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRE_TC = PW'(REFRESH_DIV - 1);

   logic [PW-1:0]         pre;
   logic                  tc;
   logic [1:0]            sel_next;
   logic [NUM_DIGITS-1:0] blank;

   bin_to_bcd_serial u_conv (
      .clk     (clk),
      .reset_n (reset_n),
      .value   (value),
      .digits  (digits),
      .busy    (busy)
   );

   // Scan prescaler: each digit is held for REFRESH_DIV cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  pre <= '0;
      else if (tc)   pre <= '0;
      else           pre <= pre + 1'b1;
   end

   always_comb tc = (pre == PRE_TC);
   always_comb sel_next = tc ? digit_sel + 2'd1 : digit_sel;

   // Digit k (k >= 1) is dark when it and every higher digit are zero.
   always_comb begin
      blank = '0;
      for (int k = 1; k < NUM_DIGITS; k++)
         blank[k] = BLANK_LZ && ((digits >> (4*k)) == '0);
   end

   // Output register: sel, bcd and an all move on the same edge, and bcd/an
   // are rebuilt every cycle so a new result shows up without tearing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digit_sel <= '0;
         bcd       <= '0;
         an        <= '1;
      end else begin
         digit_sel <= sel_next;
         bcd       <= digits[{sel_next, 2'b00} +: 4];
         an        <= blank[sel_next] ? '1 : ~(NUM_DIGITS'(1) << sel_next);
      end
   end

endmodule
